usb_xfer_ctl: RTL and testbench

Transaction-level controller above the USB token/packet layer. It consumes decoded token, handshake and data-packet events, and enforces device address and endpoint range. It tracks per-endpoint DATA0/DATA1 toggles and arbitrates endpoint ready/stall status into one handshake or IN-data response per transaction. Endpoint buffers see only single-cycle commit strobes.

---
 rtl/usb_xfer_ctl.sv | 187 ++++++++++++++++++
 tb/tb_usb_xfer_ctl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_xfer_ctl.sv
// USB transaction controller: validates tokens, tracks per-endpoint DATA0/DATA1
// toggles and issues one handshake or IN-data response per transaction.
module usb_xfer_ctl #(
    parameter int NUM_EP  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        dev_addr,
    input  logic              tkn_in,
    input  logic              tkn_out,
    input  logic              tkn_setup,
    input  logic [6:0]        tkn_addr,
    input  logic [3:0]        tkn_ep,
    input  logic              hs_ack,
    input  logic              rx_done,
    input  logic              rx_err,
    input  logic [1:0]        rx_pid,
    input  logic [NUM_EP-1:0] ep_out_ready,
    input  logic [NUM_EP-1:0] ep_in_valid,
    input  logic [NUM_EP-1:0] ep_stall,
    input  logic              tx_done,
    output logic              tx_ack,
    output logic              tx_nak,
    output logic              tx_stall,
    output logic              tx_data_start,
    output logic [1:0]        tx_data_pid,
    output logic [3:0]        cur_ep,
    output logic              out_commit,
    output logic              setup_commit,
    output logic              in_commit,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RX_DATA = 2'd1,
        S_TX_DATA = 2'd2,
        S_WAIT_HS = 2'd3
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_cnt;
    logic [3:0]        r_cur_ep;
    logic              r_setup;
    logic [1:0]        r_pid;
    logic [NUM_EP-1:0] r_tog_out;
    logic [NUM_EP-1:0] r_tog_in;
    logic              r_tx_ack, r_tx_nak, r_tx_stall, r_tx_data_start;
    logic              r_out_commit, r_setup_commit, r_in_commit;

    // Endpoint vectors widened to 16 so a 4-bit endpoint number indexes them directly.
    logic [15:0] w_stall16, w_ordy16, w_ival16, w_tout16, w_tin16, w_sel16;
    logic [NUM_EP-1:0] w_sel;
    logic        w_tkn_any, w_tkn_ok, w_tmo;

    assign w_stall16 = 16'(ep_stall);
    assign w_ordy16  = 16'(ep_out_ready);
    assign w_ival16  = 16'(ep_in_valid);
    assign w_tout16  = 16'(r_tog_out);
    assign w_tin16   = 16'(r_tog_in);
    assign w_sel16   = 16'd1 << r_cur_ep;
    assign w_sel     = w_sel16[NUM_EP-1:0];
    assign w_tkn_any = tkn_in | tkn_out | tkn_setup;
    assign w_tkn_ok  = w_tkn_any && (tkn_addr == dev_addr) && ({1'b0, tkn_ep} < 5'(NUM_EP));
    assign w_tmo     = (r_cnt == TW'(TIMEOUT));

    // Transaction state machine with registered handshake and commit pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_cur_ep        <= 4'd0;
            r_setup         <= 1'b0;
            r_pid           <= 2'b00;
            r_tog_out       <= '0;
            r_tog_in        <= '0;
            r_tx_ack        <= 1'b0;
            r_tx_nak        <= 1'b0;
            r_tx_stall      <= 1'b0;
            r_tx_data_start <= 1'b0;
            r_out_commit    <= 1'b0;
            r_setup_commit  <= 1'b0;
            r_in_commit     <= 1'b0;
        end else begin
            r_tx_ack        <= 1'b0;
            r_tx_nak        <= 1'b0;
            r_tx_stall      <= 1'b0;
            r_tx_data_start <= 1'b0;
            r_out_commit    <= 1'b0;
            r_setup_commit  <= 1'b0;
            r_in_commit     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_tkn_ok) begin
                        r_cur_ep <= tkn_ep;
                        r_setup  <= tkn_setup;
                        if (tkn_in) begin
                            if (w_stall16[tkn_ep]) begin
                                r_tx_stall <= 1'b1;
                            end else if (!w_ival16[tkn_ep]) begin
                                r_tx_nak <= 1'b1;
                            end else begin
                                r_tx_data_start <= 1'b1;
                                r_pid           <= {w_tin16[tkn_ep], 1'b0};
                                r_state         <= S_TX_DATA;
                            end
                        end else begin
                            r_state <= S_RX_DATA;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (w_tkn_any) begin
                        r_state <= S_IDLE;
                    end else if (rx_done) begin
                        r_state <= S_IDLE;
                        if (rx_err) begin
                            r_cnt <= '0;
                        end else if (r_setup) begin
                            r_tx_ack       <= 1'b1;
                            r_setup_commit <= 1'b1;
                            r_tog_out      <= r_tog_out | w_sel;
                            r_tog_in       <= r_tog_in | w_sel;
                        end else if (w_stall16[r_cur_ep]) begin
                            r_tx_stall <= 1'b1;
                        end else if (!w_ordy16[r_cur_ep]) begin
                            r_tx_nak <= 1'b1;
                        end else begin
                            // A PID that disagrees with the toggle is a retry of data already taken.
                            r_tx_ack <= 1'b1;
                            if (rx_pid == {w_tout16[r_cur_ep], 1'b0}) begin
                                r_out_commit <= 1'b1;
                                r_tog_out    <= r_tog_out ^ w_sel;
                            end else begin
                                r_out_commit <= 1'b0;
                            end
                        end
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                S_TX_DATA: begin
                    if (tx_done) begin
                        r_state <= S_WAIT_HS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_WAIT_HS: begin
                    if (w_tkn_any) begin
                        r_state <= S_IDLE;
                    end else if (hs_ack) begin
                        r_in_commit <= 1'b1;
                        r_tog_in    <= r_tog_in ^ w_sel;
                        r_state     <= S_IDLE;
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ack        = r_tx_ack;
    assign tx_nak        = r_tx_nak;
    assign tx_stall      = r_tx_stall;
    assign tx_data_start = r_tx_data_start;
    assign tx_data_pid   = r_pid;
    assign cur_ep        = r_cur_ep;
    assign out_commit    = r_out_commit;
    assign setup_commit  = r_setup_commit;
    assign in_commit     = r_in_commit;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_usb_xfer_ctl.sv
// Directed bench for usb_xfer_ctl: each task drives one scenario and checks
// pulses, busy, cur_ep and tx_data_pid against hand-computed values.
module tb_usb_xfer_ctl;

    localparam logic [6:0] P_ACK    = 7'b1000000;
    localparam logic [6:0] P_NAK    = 7'b0100000;
    localparam logic [6:0] P_STALL  = 7'b0010000;
    localparam logic [6:0] P_DSTART = 7'b0001000;
    localparam logic [6:0] P_OCOM   = 7'b0000100;
    localparam logic [6:0] P_SCOM   = 7'b0000010;
    localparam logic [6:0] P_ICOM   = 7'b0000001;
    localparam logic [6:0] P_NONE   = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] dev_addr = 7'd5;
    logic       tkn_in = 1'b0, tkn_out = 1'b0, tkn_setup = 1'b0;
    logic [6:0] tkn_addr = 7'd0;
    logic [3:0] tkn_ep = 4'd0;
    logic       hs_ack = 1'b0, rx_done = 1'b0, rx_err = 1'b0, tx_done = 1'b0;
    logic [1:0] rx_pid = 2'b00;
    logic [3:0] ep_out_ready = 4'b1111, ep_in_valid = 4'b1111, ep_stall = 4'b0000;
    logic       tx_ack, tx_nak, tx_stall, tx_data_start;
    logic [1:0] tx_data_pid;
    logic [3:0] cur_ep;
    logic       out_commit, setup_commit, in_commit, busy;
    logic [6:0] pulses;

    int checks = 0;
    int errors = 0;

    assign pulses = {tx_ack, tx_nak, tx_stall, tx_data_start, out_commit, setup_commit, in_commit};

    always #5 clk = ~clk;

    usb_xfer_ctl #(.NUM_EP(4), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .dev_addr(dev_addr),
        .tkn_in(tkn_in), .tkn_out(tkn_out), .tkn_setup(tkn_setup),
        .tkn_addr(tkn_addr), .tkn_ep(tkn_ep),
        .hs_ack(hs_ack), .rx_done(rx_done), .rx_err(rx_err), .rx_pid(rx_pid),
        .ep_out_ready(ep_out_ready), .ep_in_valid(ep_in_valid), .ep_stall(ep_stall),
        .tx_done(tx_done),
        .tx_ack(tx_ack), .tx_nak(tx_nak), .tx_stall(tx_stall),
        .tx_data_start(tx_data_start), .tx_data_pid(tx_data_pid), .cur_ep(cur_ep),
        .out_commit(out_commit), .setup_commit(setup_commit), .in_commit(in_commit),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = OUT, 1 = IN, 2 = SETUP
    task automatic send_tkn(input int kind, input logic [6:0] addr, input logic [3:0] ep);
        tkn_out   = (kind == 0);
        tkn_in    = (kind == 1);
        tkn_setup = (kind == 2);
        tkn_addr  = addr;
        tkn_ep    = ep;
        tick();
        tkn_out = 1'b0; tkn_in = 1'b0; tkn_setup = 1'b0;
    endtask

    task automatic send_rx(input logic [1:0] pid, input logic err);
        rx_done = 1'b1; rx_pid = pid; rx_err = err;
        tick();
        rx_done = 1'b0; rx_err = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic pulse_hs_ack();
        hs_ack = 1'b1;
        tick();
        hs_ack = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (cur_ep !== 4'd0) begin errors++; $display("FAIL reset_cur_ep got %0d exp 0", cur_ep); end
        checks++; if (tx_data_pid !== 2'b00) begin errors++; $display("FAIL reset_pid got %b exp 00", tx_data_pid); end
        checks++; if (pulses !== P_NONE) begin errors++; $display("FAIL reset_pulses got %b exp %b", pulses, P_NONE); end
    endtask

    task automatic test_setup();
        send_tkn(2, 7'd5, 4'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL setup_busy got %b exp 1", busy); end
        send_rx(2'b00, 1'b0);
        checks++; if (pulses !== (P_ACK | P_SCOM)) begin errors++; $display("FAIL setup_hs got %b exp %b", pulses, P_ACK | P_SCOM); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL setup_idle got %b exp 0", busy); end
        tick();
        checks++; if (pulses !== P_NONE) begin errors++; $display("FAIL setup_pulse_width got %b exp %b", pulses, P_NONE); end
        send_tkn(1, 7'd5, 4'd0);
        checks++; if (pulses !== P_DSTART) begin errors++; $display("FAIL setup_in_start got %b exp %b", pulses, P_DSTART); end
        checks++; if (tx_data_pid !== 2'b10) begin errors++; $display("FAIL setup_in_pid got %b exp 10", tx_data_pid); end
        pulse_tx_done();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL setup_wait_hs got %b exp 1", busy); end
        pulse_hs_ack();
        checks++; if (pulses !== P_ICOM) begin errors++; $display("FAIL setup_in_commit got %b exp %b", pulses, P_ICOM); end
    endtask

    task automatic test_out_toggle();
        send_tkn(0, 7'd5, 4'd1);
        checks++; if (cur_ep !== 4'd1) begin errors++; $display("FAIL out_cur_ep got %0d exp 1", cur_ep); end
        send_rx(2'b00, 1'b0);
        checks++; if (pulses !== (P_ACK | P_OCOM)) begin errors++; $display("FAIL out_data0 got %b exp %b", pulses, P_ACK | P_OCOM); end
        send_tkn(0, 7'd5, 4'd1);
        send_rx(2'b00, 1'b0);
        checks++; if (pulses !== P_ACK) begin errors++; $display("FAIL out_dup got %b exp %b", pulses, P_ACK); end
        send_tkn(0, 7'd5, 4'd1);
        send_rx(2'b10, 1'b0);
        checks++; if (pulses !== (P_ACK | P_OCOM)) begin errors++; $display("FAIL out_data1 got %b exp %b", pulses, P_ACK | P_OCOM); end
    endtask

    task automatic test_in_timeout();
        bit idle_seen;
        send_tkn(1, 7'd5, 4'd2);
        checks++; if (tx_data_pid !== 2'b00) begin errors++; $display("FAIL tmo_pid got %b exp 00", tx_data_pid); end
        pulse_tx_done();
        repeat (1000) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_early got %b exp 1", busy); end
        idle_seen = 1'b0;
        for (int i = 0; i < 100 && !idle_seen; i++) begin
            tick();
            if (busy === 1'b0) idle_seen = 1'b1;
        end
        checks++; if (idle_seen !== 1'b1) begin errors++; $display("FAIL tmo_expire got busy %b exp 0", busy); end
        send_tkn(1, 7'd5, 4'd2);
        checks++; if (tx_data_pid !== 2'b00) begin errors++; $display("FAIL tmo_retry_pid got %b exp 00", tx_data_pid); end
        pulse_tx_done();
        pulse_hs_ack();
        checks++; if (pulses !== P_ICOM) begin errors++; $display("FAIL in_commit got %b exp %b", pulses, P_ICOM); end
        send_tkn(1, 7'd5, 4'd2);
        checks++; if (tx_data_pid !== 2'b10) begin errors++; $display("FAIL in_next_pid got %b exp 10", tx_data_pid); end
        pulse_tx_done();
        pulse_hs_ack();
    endtask

    task automatic test_stall_nak();
        ep_stall = 4'b0010;
        send_tkn(1, 7'd5, 4'd1);
        checks++; if (pulses !== P_STALL) begin errors++; $display("FAIL in_stall got %b exp %b", pulses, P_STALL); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL in_stall_busy got %b exp 0", busy); end
        send_tkn(0, 7'd5, 4'd1);
        send_rx(2'b00, 1'b0);
        checks++; if (pulses !== P_STALL) begin errors++; $display("FAIL out_stall got %b exp %b", pulses, P_STALL); end
        ep_stall = 4'b0000;
        ep_out_ready = 4'b1101;
        send_tkn(0, 7'd5, 4'd1);
        send_rx(2'b00, 1'b0);
        checks++; if (pulses !== P_NAK) begin errors++; $display("FAIL out_nak got %b exp %b", pulses, P_NAK); end
        ep_out_ready = 4'b1111;
        ep_in_valid = 4'b1011;
        send_tkn(1, 7'd5, 4'd2);
        checks++; if (pulses !== P_NAK) begin errors++; $display("FAIL in_nak got %b exp %b", pulses, P_NAK); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL in_nak_busy got %b exp 0", busy); end
        ep_in_valid = 4'b1111;
    endtask

    task automatic test_drop_and_err();
        send_tkn(1, 7'd6, 4'd0);
        checks++; if ({busy, pulses} !== {1'b0, P_NONE}) begin errors++; $display("FAIL drop_addr got %b exp 0", {busy, pulses}); end
        send_tkn(1, 7'd5, 4'd4);
        checks++; if ({busy, pulses} !== {1'b0, P_NONE}) begin errors++; $display("FAIL drop_ep_in got %b exp 0", {busy, pulses}); end
        send_tkn(0, 7'd5, 4'd4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_ep_out got %b exp 0", busy); end
        checks++; if (cur_ep !== 4'd2) begin errors++; $display("FAIL drop_cur_ep got %0d exp 2", cur_ep); end
        send_tkn(0, 7'd5, 4'd3);
        send_rx(2'b00, 1'b1);
        checks++; if ({busy, pulses} !== {1'b0, P_NONE}) begin errors++; $display("FAIL rx_err got %b exp 0", {busy, pulses}); end
        send_tkn(0, 7'd5, 4'd3);
        send_rx(2'b00, 1'b0);
        checks++; if (pulses !== (P_ACK | P_OCOM)) begin errors++; $display("FAIL rx_err_tog got %b exp %b", pulses, P_ACK | P_OCOM); end
    endtask

    task automatic test_abort();
        send_tkn(0, 7'd5, 4'd3);
        send_tkn(1, 7'd5, 4'd0);
        checks++; if ({busy, pulses} !== {1'b0, P_NONE}) begin errors++; $display("FAIL abort_tkn got %b exp 0", {busy, pulses}); end
        send_rx(2'b10, 1'b0);
        checks++; if (pulses !== P_NONE) begin errors++; $display("FAIL abort_late_rx got %b exp %b", pulses, P_NONE); end
    endtask

    task automatic test_reset_mid();
        send_tkn(1, 7'd5, 4'd0);
        pulse_tx_done();
        pulse_hs_ack();
        send_tkn(1, 7'd5, 4'd0);
        checks++; if (tx_data_pid !== 2'b10) begin errors++; $display("FAIL rstmid_pre_pid got %b exp 10", tx_data_pid); end
        pulse_tx_done();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({busy, pulses, tx_data_pid, cur_ep} !== 14'd0) begin errors++; $display("FAIL rstmid_state got %b exp 0", {busy, pulses, tx_data_pid, cur_ep}); end
        pulse_hs_ack();
        checks++; if (pulses !== P_NONE) begin errors++; $display("FAIL rstmid_late_ack got %b exp %b", pulses, P_NONE); end
        send_tkn(1, 7'd5, 4'd0);
        checks++; if (tx_data_pid !== 2'b00) begin errors++; $display("FAIL rstmid_in_tog got %b exp 00", tx_data_pid); end
        pulse_tx_done();
        pulse_hs_ack();
        send_tkn(0, 7'd5, 4'd3);
        send_rx(2'b00, 1'b0);
        checks++; if (pulses !== (P_ACK | P_OCOM)) begin errors++; $display("FAIL rstmid_out_tog got %b exp %b", pulses, P_ACK | P_OCOM); end
    endtask

    initial begin
        test_reset();
        test_setup();
        test_out_toggle();
        test_in_timeout();
        test_stall_nak();
        test_drop_and_err();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
